vend_dispenser: RTL and testbench

Downstream stage of the coin-accepting vending FSM. It consumes that FSM's one-cycle vend strobe and change code, queues pending vends in a small FIFO, and drives the mechanical drink and change hoppers one item at a time over req/ack handshakes. Coins are paced with a programmable gap between them. Change is counted in 0.5-unit coins, 0..3 per vend.

---
 rtl/vend_dispenser.sv | 146 ++++++++++++++
 tb/tb_vend_dispenser.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_dispenser.sv
// vend_dispenser: queues vend strobes from the coin-accepting FSM and drives
// the drink and change hoppers one item at a time, pacing coins with GAP
// idle cycles between successive hopper requests.
//
// Handshake: a request (drink_req / coin_req) is a decode of the registered
// state. It stays high until its ack is sampled high at a posedge and then
// drops on the next cycle. An ack seen while its request is low is ignored.
// An ack held high across several cycles completes only one request, because
// the request itself falls after the first accepting edge.
module vend_dispenser #(
    parameter int DEPTH = 4,
    parameter int GAP   = 2,
    parameter int CW    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     vend_in,
    input  logic [CW-1:0]            change_in,
    output logic                     drink_req,
    input  logic                     drink_ack,
    output logic                     coin_req,
    input  logic                     coin_ack,
    input  logic                     overflow_clr,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     overflow,
    output logic [1:0]               state_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DROP = 2'd1,
        S_GAP  = 2'd2,
        S_COIN = 2'd3
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [GW-1:0]   gap_cnt, gap_nx;

    logic [CW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            overflow_r;

    logic            full;
    logic            pop;
    logic            push_ok;
    logic            drop_vend;

    // A pop frees a slot on the same edge, so a full queue still accepts a
    // vend when the FSM is popping.
    assign full      = (count == (AW+1)'(DEPTH));
    assign pop       = (state == S_IDLE) && (count != '0);
    assign push_ok   = vend_in && (!full || pop);
    assign drop_vend = vend_in && full && !pop;

    // Queue storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= change_in;
    end

    // Queue pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop)      count <= count + (AW+1)'(1);
            else if (pop && !push_ok) count <= count - (AW+1)'(1);
            // A new drop wins over a simultaneous clear.
            if (drop_vend)         overflow_r <= 1'b1;
            else if (overflow_clr) overflow_r <= 1'b0;
        end
    end

    // FSM state, remaining coin count and gap counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            gap_cnt <= gap_nx;
        end
    end

    // Next-state logic: pop a vend, request the drink, then pace the coins.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        gap_nx   = gap_cnt;
        case (state)
            S_IDLE: begin
                if (pop) begin
                    cnt_nx   = mem[rd_ptr];
                    state_nx = S_DROP;
                end
            end
            S_DROP: begin
                if (drink_ack) begin
                    if (cnt == '0) begin
                        state_nx = S_IDLE;
                    end else begin
                        gap_nx   = GW'(GAP - 1);
                        state_nx = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == '0) state_nx = S_COIN;
                else               gap_nx   = gap_cnt - GW'(1);
            end
            S_COIN: begin
                if (coin_ack) begin
                    // cnt is nonzero whenever we are in COIN.
                    cnt_nx = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state_nx = S_IDLE;
                    end else begin
                        gap_nx   = GW'(GAP - 1);
                        state_nx = S_GAP;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign drink_req = (state == S_DROP);
    assign coin_req  = (state == S_COIN);
    assign busy      = (state != S_IDLE) || (count != '0);
    assign pending   = count;
    assign overflow  = overflow_r;
    assign state_dbg = state;

endmodule

// File: tb/tb_vend_dispenser.sv
// Bench for vend_dispenser: directed scenarios plus a randomized phase, all
// checked cycle by cycle against an action-script reference model.
module tb_vend_dispenser;

    localparam int DEPTH = 4;
    localparam int GAP   = 2;
    localparam int CW    = 2;
    localparam int PW    = $clog2(DEPTH) + 1;

    localparam int TOK_GAP   = 0;
    localparam int TOK_DRINK = 1;
    localparam int TOK_COIN  = 2;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          vend_in = 1'b0;
    logic [CW-1:0] change_in = '0;
    logic          drink_ack = 1'b0;
    logic          coin_ack = 1'b0;
    logic          overflow_clr = 1'b0;
    logic          drink_req, coin_req, busy, overflow;
    logic [PW-1:0] pending;
    logic [1:0]    state_dbg;

    always #5 clk = ~clk;

    vend_dispenser #(.DEPTH(DEPTH), .GAP(GAP), .CW(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .vend_in      (vend_in),
        .change_in    (change_in),
        .drink_req    (drink_req),
        .drink_ack    (drink_ack),
        .coin_req     (coin_req),
        .coin_ack     (coin_ack),
        .overflow_clr (overflow_clr),
        .busy         (busy),
        .pending      (pending),
        .overflow     (overflow),
        .state_dbg    (state_dbg)
    );

    // ---------------- scoreboard / reference model ----------------
    int tests_run  = 0;
    int fail_count = 0;

    logic [CW-1:0] exp_q[$];   // queued vends (change values)
    int            act_q[$];   // remaining hopper actions of the current vend
    bit            m_ovf;

    bit auto_ack = 0;
    bit prev_d = 0, prev_c = 0;
    int drinks_acc = 0, coins_acc = 0;
    int drink_hi = 0, coin_hi = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            fail_count++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        exp_q.delete();
        act_q.delete();
        m_ovf = 1'b0;
    endfunction

    // One clock edge of the reference: a vend expands into a script of
    // actions (drink, then GAP idle cycles before each coin).
    function automatic void model_edge();
        bit full;
        bit pop;
        logic [CW-1:0] c;
        full = (exp_q.size() == DEPTH);
        pop  = (act_q.size() == 0) && (exp_q.size() != 0);
        if (act_q.size() > 0) begin
            if (act_q[0] == TOK_GAP ||
                (act_q[0] == TOK_DRINK && drink_ack) ||
                (act_q[0] == TOK_COIN && coin_ack))
                void'(act_q.pop_front());
        end
        if (pop) begin
            c = exp_q.pop_front();
            act_q.push_back(TOK_DRINK);
            for (int i = 0; i < int'(c); i++) begin
                for (int g = 0; g < GAP; g++) act_q.push_back(TOK_GAP);
                act_q.push_back(TOK_COIN);
            end
        end
        if (vend_in && (!full || pop)) exp_q.push_back(change_in);
        if (vend_in && full && !pop) m_ovf = 1'b1;
        else if (overflow_clr)       m_ovf = 1'b0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        bit acc_d, acc_c;
        bit e_drink, e_coin;
        acc_d = drink_req && drink_ack;
        acc_c = coin_req && coin_ack;
        @(posedge clk);
        if (!rst) model_reset();
        else      model_edge();
        #1;
        if (rst) begin
            if (acc_d) drinks_acc++;
            if (acc_c) coins_acc++;
        end
        e_drink = (act_q.size() > 0) && (act_q[0] == TOK_DRINK);
        e_coin  = (act_q.size() > 0) && (act_q[0] == TOK_COIN);
        check_eq("drink_req", 32'(drink_req), 32'(e_drink));
        check_eq("coin_req",  32'(coin_req),  32'(e_coin));
        check_eq("busy",      32'(busy),      32'((act_q.size() > 0) || (exp_q.size() > 0)));
        check_eq("pending",   32'(pending),   32'(exp_q.size()));
        check_eq("overflow",  32'(overflow),  32'(m_ovf));
        check_eq("req_excl",  32'(drink_req && coin_req), 32'(0));
        if (drink_req) drink_hi++;
        if (coin_req)  coin_hi++;
        if (auto_ack) begin
            drink_ack = drink_req && prev_d;
            coin_ack  = coin_req && prev_c;
        end
        prev_d = drink_req;
        prev_c = coin_req;
    endtask

    task automatic clear_counts();
        drinks_acc = 0; coins_acc = 0; drink_hi = 0; coin_hi = 0;
    endtask

    task automatic vend(input int ch);
        vend_in = 1'b1;
        change_in = CW'(ch);
        step();
        vend_in = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        step();
        while (busy && n < budget) begin
            step();
            n++;
        end
        check_eq("idle_wait", 32'(busy), 32'(0));
    endtask

    task automatic wait_coin(input int budget);
        int n = 0;
        while (!coin_req && n < budget) begin
            step();
            n++;
        end
        check_eq("coin_wait", 32'(coin_req), 32'(1));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ch6[6];
        ch6 = '{1, 0, 2, 3, 1, 2};
        model_reset();

        // Reset held with random inputs: everything stays zero.
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            vend_in      = 1'($urandom_range(0, 1));
            change_in    = CW'($urandom_range(0, 3));
            drink_ack    = 1'($urandom_range(0, 1));
            coin_ack     = 1'($urandom_range(0, 1));
            overflow_clr = 1'($urandom_range(0, 1));
            step();
        end
        vend_in = 0; drink_ack = 0; coin_ack = 0; overflow_clr = 0;
        rst = 1'b1;
        step();

        // Single vend, no change; latency and handshake length.
        clear_counts();
        auto_ack = 1;
        vend(0);
        check_eq("lat_pending1", 32'(pending), 32'(1));
        step();
        check_eq("lat_drink_req", 32'(drink_req), 32'(1));
        check_eq("lat_pending0", 32'(pending), 32'(0));
        wait_idle(20);
        check_eq("t1_drink_hi", 32'(drink_hi), 32'(2));
        check_eq("t1_coin_hi", 32'(coin_hi), 32'(0));
        check_eq("t1_drinks", 32'(drinks_acc), 32'(1));

        // Change 3 with immediate acks.
        clear_counts();
        vend(3);
        wait_idle(60);
        check_eq("t2_drinks", 32'(drinks_acc), 32'(1));
        check_eq("t2_coins", 32'(coins_acc), 32'(3));
        check_eq("t2_coin_hi", 32'(coin_hi), 32'(6));

        // Back-to-back vends with drink_ack held low: the sixth overflows.
        clear_counts();
        auto_ack = 0; drink_ack = 0; coin_ack = 0;
        for (int i = 0; i < 6; i++) vend(ch6[i]);
        check_eq("t3_pending_full", 32'(pending), 32'(4));
        check_eq("t3_overflow_set", 32'(overflow), 32'(1));
        auto_ack = 1;
        wait_idle(200);
        check_eq("t3_drinks", 32'(drinks_acc), 32'(5));
        check_eq("t3_coins", 32'(coins_acc), 32'(7));
        check_eq("t3_overflow_sticky", 32'(overflow), 32'(1));
        overflow_clr = 1; step(); overflow_clr = 0;
        check_eq("t3_overflow_clr", 32'(overflow), 32'(0));

        // Push and pop on the same edge while full.
        clear_counts();
        auto_ack = 0; drink_ack = 0; coin_ack = 0;
        vend(0);
        step();
        vend(1); vend(2); vend(3); vend(0);
        check_eq("t4_full", 32'(pending), 32'(4));
        drink_ack = 1; step(); drink_ack = 0;
        vend(3);
        check_eq("t4_pending_kept", 32'(pending), 32'(4));
        check_eq("t4_no_overflow", 32'(overflow), 32'(0));
        check_eq("t4_popped", 32'(drink_req), 32'(1));
        auto_ack = 1;
        wait_idle(300);
        check_eq("t4_drinks", 32'(drinks_acc), 32'(6));
        check_eq("t4_coins", 32'(coins_acc), 32'(9));

        // Spurious coin_ack and a long-held drink_ack.
        clear_counts();
        auto_ack = 0;
        coin_ack = 1;
        for (int i = 0; i < 3; i++) step();
        coin_ack = 0;
        vend(1);
        drink_ack = 1;
        for (int i = 0; i < 5; i++) begin
            coin_ack = (i == 2);
            step();
        end
        drink_ack = 0; coin_ack = 0;
        auto_ack = 1;
        wait_idle(40);
        check_eq("t5_drinks", 32'(drinks_acc), 32'(1));
        check_eq("t5_coins", 32'(coins_acc), 32'(1));

        // Randomized traffic.
        auto_ack = 0;
        for (int i = 0; i < 400; i++) begin
            vend_in      = ($urandom_range(0, 5) == 0);
            change_in    = CW'($urandom_range(0, 3));
            drink_ack    = ($urandom_range(0, 2) == 0);
            coin_ack     = ($urandom_range(0, 2) == 0);
            overflow_clr = ($urandom_range(0, 15) == 0);
            step();
        end
        vend_in = 0; drink_ack = 0; coin_ack = 0; overflow_clr = 0;
        auto_ack = 1;
        wait_idle(400);
        overflow_clr = 1; step(); overflow_clr = 0;

        // Reset in COIN with cnt=2 and pending=3.
        auto_ack = 0; drink_ack = 0; coin_ack = 0;
        vend(3);
        step();
        vend(1); vend(1); vend(1);
        drink_ack = 1; step(); drink_ack = 0;
        wait_coin(10);
        coin_ack = 1; step(); coin_ack = 0;
        wait_coin(10);
        check_eq("t6_pending3", 32'(pending), 32'(3));
        #2;
        rst = 1'b0;
        #1;
        check_eq("t6_async_coin_req", 32'(coin_req), 32'(0));
        check_eq("t6_async_busy", 32'(busy), 32'(0));
        check_eq("t6_async_pending", 32'(pending), 32'(0));
        model_reset();
        prev_d = 0; prev_c = 0;
        step(); step();
        rst = 1'b1;
        step();
        check_eq("t6_post_pending", 32'(pending), 32'(0));
        check_eq("t6_post_overflow", 32'(overflow), 32'(0));

        // Overflow set wins over a coincident clear, then clear works.
        for (int i = 0; i < 6; i++) vend(i % 4);
        check_eq("t7_overflow_set", 32'(overflow), 32'(1));
        vend_in = 1; change_in = 2'd1; overflow_clr = 1;
        step();
        vend_in = 0; overflow_clr = 0;
        check_eq("t7_set_wins", 32'(overflow), 32'(1));
        overflow_clr = 1; step(); overflow_clr = 0;
        check_eq("t7_cleared", 32'(overflow), 32'(0));
        auto_ack = 1;
        wait_idle(300);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
